// File: rtl/frame_serializer.sv
// -----------------------------------------------------------------------------
// frame_serializer
//
// Transmit-side byte framer. Parallel bytes arrive over a valid/ready
// handshake into a one-entry holding buffer. Each group of FRAME_LEN data
// bytes is preceded by the SYNC byte, and the whole frame is shifted out
// MSB-first on ser_out, one bit per ser_clk. If the next frame's first byte
// is already buffered when a frame ends, the next frame follows with no gap.
//
// Parameters
//   N          bits per byte (shift register / bit counter width)
//   SYNC       sync byte value sent at the start of every frame
//   FRAME_LEN  data bytes per frame, 1..255
//
// Ports
//   ser_clk      in   serial bit clock, all state updates on its rising edge
//   reset_n      in   asynchronous active-low reset
//   par_in       in   data byte offered by the source
//   par_valid    in   par_in is valid
//   par_ready    out  holding buffer empty; transfer on valid && ready
//   ser_out      out  serial data, MSB-first
//   byte_strobe  out  high during the first bit cycle of every byte sent
//   sync_active  out  high during the N cycles of every sync byte
//   underrun     out  one-cycle pulse when a frame is aborted for lack of data
// -----------------------------------------------------------------------------
module frame_serializer #(
    parameter int N         = 8,
    parameter int SYNC      = 171,
    parameter int FRAME_LEN = 4
) (
    input  logic         ser_clk,
    input  logic         reset_n,
    input  logic [N-1:0] par_in,
    input  logic         par_valid,
    output logic         par_ready,
    output logic         ser_out,
    output logic         byte_strobe,
    output logic         sync_active,
    output logic         underrun
);

    localparam int BIT_W  = (N > 1) ? $clog2(N) : 1;
    localparam int BYTE_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [N-1:0]      SYNC_BYTE = N'(SYNC);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(N - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA
    } state_t;

    state_t            r_state;
    logic [N-1:0]      r_buf;
    logic              r_buf_full;
    logic [N-1:0]      r_shreg;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [BYTE_W-1:0] r_byte_cnt;
    logic              r_underrun;

    state_t            w_state_nxt;
    logic [N-1:0]      w_shreg_nxt;
    logic [BIT_W-1:0]  w_bit_cnt_nxt;
    logic [BYTE_W-1:0] w_byte_cnt_nxt;
    logic              w_underrun_nxt;
    logic              w_drain;
    logic              w_accept;
    logic              w_last_bit;
    logic              w_last_byte;

    // An accept needs an empty buffer, so it can never coincide with a drain.
    assign w_accept    = par_valid && !r_buf_full;
    assign w_last_bit  = (r_bit_cnt == LAST_BIT);
    assign w_last_byte = (r_byte_cnt == LAST_BYTE);

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge ser_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath control
    // -------------------------------------------------------------------------
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_shreg_nxt    = {r_shreg[N-2:0], 1'b0};
        w_bit_cnt_nxt  = r_bit_cnt + BIT_W'(1);
        w_byte_cnt_nxt = r_byte_cnt;
        w_underrun_nxt = 1'b0;
        w_drain        = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                // Line held at 0 and counters parked until a byte is buffered.
                w_shreg_nxt    = '0;
                w_bit_cnt_nxt  = '0;
                w_byte_cnt_nxt = '0;
                if (r_buf_full) begin
                    w_shreg_nxt = SYNC_BYTE;
                    w_state_nxt = ST_SYNC;
                end
            end

            ST_SYNC: begin
                // Entry to SYNC always has a byte waiting, so no underrun here.
                if (w_last_bit) begin
                    w_shreg_nxt    = r_buf;
                    w_bit_cnt_nxt  = '0;
                    w_byte_cnt_nxt = '0;
                    w_drain        = 1'b1;
                    w_state_nxt    = ST_DATA;
                end
            end

            ST_DATA: begin
                if (w_last_bit) begin
                    w_bit_cnt_nxt = '0;
                    if (!w_last_byte) begin
                        if (r_buf_full) begin
                            w_shreg_nxt    = r_buf;
                            w_byte_cnt_nxt = r_byte_cnt + BYTE_W'(1);
                            w_drain        = 1'b1;
                        end else begin
                            // Mid-frame starvation: abandon the frame.
                            w_underrun_nxt = 1'b1;
                            w_shreg_nxt    = '0;
                            w_byte_cnt_nxt = '0;
                            w_state_nxt    = ST_IDLE;
                        end
                    end else if (r_buf_full) begin
                        // Next frame's first byte is ready: chain without a gap.
                        w_shreg_nxt    = SYNC_BYTE;
                        w_byte_cnt_nxt = '0;
                        w_state_nxt    = ST_SYNC;
                    end else begin
                        w_shreg_nxt    = '0;
                        w_byte_cnt_nxt = '0;
                        w_state_nxt    = ST_IDLE;
                    end
                end
            end

            default: begin
                w_shreg_nxt    = '0;
                w_bit_cnt_nxt  = '0;
                w_byte_cnt_nxt = '0;
                w_state_nxt    = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge ser_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_underrun <= 1'b0;
            r_buf_full <= 1'b0;
        end else begin
            r_shreg    <= w_shreg_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_underrun <= w_underrun_nxt;
            if (w_accept) begin
                r_buf_full <= 1'b1;
            end else if (w_drain) begin
                r_buf_full <= 1'b0;
            end
        end
    end

    // NOTE: the holding buffer's contents need no reset; r_buf_full alone
    // decides whether they mean anything, and reset clears that flag.
    always_ff @(posedge ser_clk) begin
        if (w_accept) begin
            r_buf <= par_in;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign par_ready   = !r_buf_full;
    assign ser_out     = r_shreg[N-1];
    assign byte_strobe = (r_state != ST_IDLE) && (r_bit_cnt == '0);
    assign sync_active = (r_state == ST_SYNC);
    assign underrun    = r_underrun;

endmodule

// File: tb/tb_frame_serializer.sv
// -----------------------------------------------------------------------------
// tb_frame_serializer
//
// Drives byte sequences into frame_serializer and compares every cycle of
// ser_out / byte_strobe / sync_active / underrun / par_ready against a
// reference built from the framing rules: the expected bit stream is the
// byte list split into groups of FRAME_LEN, each preceded by 0xAB, sent
// MSB-first starting one cycle after the first byte is accepted. A short
// final group ends in an underrun pulse; each byte is expected to leave the
// holding buffer at the start of its own slot in that stream.
// -----------------------------------------------------------------------------
module tb_frame_serializer;

    localparam int         N      = 8;
    localparam int         FL     = 4;
    localparam logic [7:0] SYNC_B = 8'hAB;

    logic       ser_clk;
    logic       reset_n;
    logic [7:0] par_in;
    logic       par_valid;
    logic       par_ready;
    logic       ser_out;
    logic       byte_strobe;
    logic       sync_active;
    logic       underrun;

    frame_serializer #(
        .N         (N),
        .SYNC      (171),
        .FRAME_LEN (FL)
    ) dut (
        .ser_clk     (ser_clk),
        .reset_n     (reset_n),
        .par_in      (par_in),
        .par_valid   (par_valid),
        .par_ready   (par_ready),
        .ser_out     (ser_out),
        .byte_strobe (byte_strobe),
        .sync_active (sync_active),
        .underrun    (underrun)
    );

    initial ser_clk = 1'b0;
    always #5 ser_clk = ~ser_clk;

    int         n_checks  = 0;
    int         n_errors  = 0;
    int         cyc       = 0;
    int         max_delay = 0;
    logic [7:0] src_q[$];

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge ser_clk);
        #1;
        cyc++;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".ser_out"},     ser_out,     1'b0);
        check({tag, ".byte_strobe"}, byte_strobe, 1'b0);
        check({tag, ".sync_active"}, sync_active, 1'b0);
        check({tag, ".underrun"},    underrun,    1'b0);
        check({tag, ".par_ready"},   par_ready,   1'b1);
    endtask

    // Feed src_q with a random gap (0..max_delay cycles) after each accept,
    // and compare every cycle with the expected framed stream. If abort_t is
    // non-negative, reset is asserted mid-cycle at that stream bit and left low.
    task automatic run_stream(input int abort_t);
        logic [7:0] slots[$];
        logic       slot_sync[$];
        logic [7:0] cur;
        int         m, nbits, idx, wait_cnt, start, held, t;
        logic       partial, accept, done;
        logic       exp_ready, exp_ser, exp_stb, exp_syn, exp_und;

        m = src_q.size();
        for (int j = 0; j < m; j++) begin
            if (j % FL == 0) begin
                slots.push_back(SYNC_B);
                slot_sync.push_back(1'b1);
            end
            slots.push_back(src_q[j]);
            slot_sync.push_back(1'b0);
        end
        nbits    = slots.size() * N;
        partial  = (m % FL) != 0;
        idx      = 0;
        start    = -1;
        held     = -1;
        done     = 1'b0;
        wait_cnt = $urandom_range(max_delay, 0);
        par_valid = 1'b0;

        for (int c = 0; c < 3000 && !done; c++) begin
            if (!par_valid && idx < m) begin
                if (wait_cnt == 0) begin
                    par_valid = 1'b1;
                    par_in    = src_q[idx];
                end else begin
                    wait_cnt--;
                end
            end
            accept = par_valid && par_ready;
            tick();
            if (accept) begin
                if (idx == 0) start = cyc + 1;
                held      = idx;
                idx++;
                par_valid = 1'b0;
                wait_cnt  = $urandom_range(max_delay, 0);
            end
            // Data byte j leaves the buffer at the start of stream slot
            // j + (frames before it) + 1.
            if (held >= 0 && cyc >= start + N * (held + held / FL + 1)) held = -1;
            exp_ready = (held < 0);

            t = -1;
            exp_ser = 1'b0;
            exp_stb = 1'b0;
            exp_syn = 1'b0;
            exp_und = 1'b0;
            if (start >= 0 && cyc >= start) begin
                t = cyc - start;
                if (t < nbits) begin
                    cur     = slots[t / N];
                    exp_ser = cur[N - 1 - (t % N)];
                    exp_stb = (t % N) == 0;
                    exp_syn = slot_sync[t / N];
                end else begin
                    exp_und = partial && (t == nbits);
                end
            end

            check("par_ready",   par_ready,   exp_ready);
            check("ser_out",     ser_out,     exp_ser);
            check("byte_strobe", byte_strobe, exp_stb);
            check("sync_active", sync_active, exp_syn);
            check("underrun",    underrun,    exp_und);

            if (abort_t >= 0 && t == abort_t) begin
                par_valid = 1'b0;
                #2 reset_n = 1'b0;
                #1;
                check("async_rst.ser_out",     ser_out,     1'b0);
                check("async_rst.par_ready",   par_ready,   1'b1);
                check("async_rst.byte_strobe", byte_strobe, 1'b0);
                check("async_rst.sync_active", sync_active, 1'b0);
                check("async_rst.underrun",    underrun,    1'b0);
                done = 1'b1;
            end else if (t >= nbits + 3) begin
                done = 1'b1;
            end
        end
        check("stream_completed", done, 1'b1);
        par_valid = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        par_valid = 1'b0;
        par_in    = 8'h00;

        // Reset held for three cycles, then idle with nothing offered.
        repeat (3) begin
            tick();
            check_idle("reset");
        end
        reset_n = 1'b1;
        repeat (4) begin
            tick();
            check_idle("idle");
        end

        // Single frame, source always ready.
        max_delay = 0;
        src_q = '{8'h12, 8'h34, 8'h56, 8'h78};
        run_stream(-1);

        // Two frames back-to-back with valid held high (backpressure).
        src_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_stream(-1);

        // Underrun after the second data byte.
        src_q = '{8'hC3, 8'h5A};
        run_stream(-1);

        // Random data with random but timely gaps, three full frames.
        max_delay = 5;
        src_q.delete();
        for (int i = 0; i < 12; i++) src_q.push_back(8'($urandom_range(255, 0)));
        run_stream(-1);

        // Random lengths: some end on a frame boundary, some underrun.
        repeat (4) begin
            src_q.delete();
            for (int i = 0, n = $urandom_range(9, 1); i < n; i++)
                src_q.push_back(8'($urandom_range(255, 0)));
            run_stream(-1);
        end

        // Reset during bit 3 of data byte 1 while the buffer holds byte 2.
        max_delay = 0;
        src_q = '{8'h11, 8'h3C, 8'h5F};
        run_stream(20);
        repeat (2) begin
            tick();
            check_idle("in_reset");
        end
        reset_n = 1'b1;
        repeat (4) begin
            tick();
            check_idle("buffer_discarded");
        end

        // A fresh frame starts cleanly after the reset.
        src_q = '{8'h9E};
        run_stream(-1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/frame_serializer.md
# frame_serializer

Transmit-side counterpart of the serial byte framer. It accepts parallel bytes over a valid/ready handshake and prepends a sync byte (0xAB) to each group of FRAME_LEN data bytes. It shifts the result out MSB-first on one serial line, one bit per `ser_clk`. Its output drives the receive framer's `ser_in` directly; a loopback recovers each byte on `par_out` with `decode_AB` asserted after every sync byte.

## Interface
- `N`, 8: bits per byte; sets shift-register and bit-counter width.
- `SYNC`, 171 (0xAB): sync byte sent at the start of every frame.
- `FRAME_LEN`, 4: data bytes per frame, range 1..255.

- `ser_clk`, in, 1: serial bit clock; all state is updated on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `par_in`, in, 8: data byte offered by the upstream source.
- `par_valid`, in, 1: `par_in` is valid.
- `par_ready`, out, 1: the holding buffer is empty. A byte transfers on a rising edge where `par_valid` && `par_ready`.
- `ser_out`, out, 1: serial data, MSB-first.
- `byte_strobe`, out, 1: high during the bit-7 (first) cycle of every transmitted byte, sync byte included.
- `sync_active`, out, 1: high during the 8 cycles of every sync byte.
- `underrun`, out, 1: one-cycle pulse when a frame is aborted because the holding buffer was empty.

## Operation
- Datapath:
  - 1-entry holding buffer `buf` with a `buf_full` flag.
  - N-bit shift register `shreg`.
  - `bit_cnt`, 0..N-1.
  - `byte_cnt`, 0..FRAME_LEN-1.
- `par_ready` = !`buf_full`; it is a combinational function of a register only.
- Handshake accept: `buf` <= `par_in` and `buf_full` <= 1. A drain and an accept can never fall on the same edge, because an accept requires an empty buffer.
- `ser_out` = `shreg[N-1]`. On each edge that is not a load edge, `shreg` shifts left by one, filling with 0, and `bit_cnt` increments.
- IDLE (reset state):
  - `shreg` = 0, so `ser_out` = 0.
  - `bit_cnt` = 0 and `byte_cnt` = 0.
  - If `buf_full`: load `shreg` <= SYNC, `bit_cnt` <= 0, go to SYNC.
- SYNC:
  - At `bit_cnt`==N-1, load `shreg` <= `buf`, clear `buf_full`, set `byte_cnt` <= 0, go to DATA.
  - A buffer is always full on entry to SYNC, so no underrun check is needed here.
- DATA:
  - At `bit_cnt`==N-1 with `byte_cnt` < FRAME_LEN-1:
    - If `buf_full`: load `buf`, drain it, `byte_cnt`++.
    - Otherwise: pulse `underrun`, clear `shreg`, go to IDLE.
  - At `bit_cnt`==N-1 with `byte_cnt`==FRAME_LEN-1:
    - If `buf_full`: load SYNC and go to SYNC, giving a back-to-back frame with no idle gap.
    - Otherwise: go to IDLE with no underrun pulse.
- `byte_strobe` = (state != IDLE) && `bit_cnt`==0.
- `sync_active` = (state == SYNC).
- Reset asserted mid-operation clears everything immediately:
  - the FSM goes to IDLE;
  - `buf_full`, `shreg`, `bit_cnt`, `byte_cnt` and `underrun` clear;
  - any buffered byte is discarded;
  - `ser_out` falls to 0 without waiting for a clock.

## Timing
- Reset values:
  - `ser_out`, `byte_strobe`, `sync_active`, `underrun` = 0.
  - `par_ready` = 1.
- Latency, with the first byte accepted at edge k:
  - At edge k+1, SYNC is loaded and `ser_out` shows SYNC bit 7 from edge k+1 until edge k+2.
  - The sync byte occupies edges k+1..k+8.
  - At edge k+9, data byte 0 is loaded and `par_ready` rises.
- Each byte occupies exactly N cycles.
- A full frame occupies (FRAME_LEN+1)·N cycles.
- To sustain back-to-back frames, the source must deliver each byte within N-1 cycles of `par_ready` rising.
- `underrun` is asserted in the cycle immediately after the aborting edge, which is also the first IDLE cycle.

## Test plan
- **Reset:** hold `reset_n`=0 for 3 cycles, then release.
  - Expect `ser_out`/`byte_strobe`/`sync_active`/`underrun`=0 and `par_ready`=1.
  - Expect `ser_out` to stay 0 with `par_valid`=0.
- **Single frame:** with FRAME_LEN=4, supply 0x12, 0x34, 0x56, 0x78 whenever ready.
  - Expect `ser_out` = 1010_1011, 0001_0010, 0011_0100, 0101_0110, 0111_1000 (40 bits), then 0.
  - Expect `byte_strobe` ×5 at 8-cycle spacing.
  - Expect `sync_active` high for the first 8 cycles only.
- **Back-to-back:** supply 8 bytes 0x01..0x08 with no stalls.
  - Expect the bit stream AB 01 02 03 04 AB 05 06 07 08 with no idle cycle between frames.
  - In loopback, the framer shows `decode_AB` after each AB.
- **Underrun:** supply only 0xC3 and 0x5A.
  - Expect AB C3 5A to be sent.
  - Expect `underrun`=1 for exactly one cycle after the last bit of 0x5A, then IDLE with `ser_out`=0.
- **Backpressure:** hold `par_valid`=1 with the value changing only after acceptance, and verify the acceptance edges.
  - Expect no byte to be dropped or duplicated.
  - Expect `par_ready` low from acceptance until that byte is loaded.
- **Reset mid-byte:** drop `reset_n` during bit 3 of data byte 1 with `buf_full`=1.
  - Expect `ser_out`=0 asynchronously and the buffered byte lost.
  - After release, a new byte produces a fresh frame starting with AB.
